// File: rtl/cache_pkg.sv
// Shared definitions for the cache tag/data store and its controller:
// log2 helper, derived geometry widths and the flush walker state encoding.
package cache_pkg;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_SCAN = 2'd1,
        FL_WB   = 2'd2,
        FL_DONE = 2'd3
    } flush_state_e;

    function automatic int log2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int num_sets_f(input int cache_size, input int block_size, input int ways);
        return cache_size * 8 / block_size / ways;
    endfunction

    function automatic int offset_width_f(input int block_size, input int data_width);
        return log2_f(block_size / data_width);
    endfunction

    function automatic int index_width_f(input int cache_size, input int block_size, input int ways);
        return log2_f(num_sets_f(cache_size, block_size, ways));
    endfunction

    function automatic int tag_width_f(input int addr_width, input int data_width,
                                       input int block_size, input int cache_size, input int ways);
        return addr_width - index_width_f(cache_size, block_size, ways)
                          - offset_width_f(block_size, data_width);
    endfunction

    // Way-select ports stay at least one bit wide so a direct-mapped build still has legal ports.
    function automatic int way_width_f(input int ways);
        return (ways > 1) ? log2_f(ways) : 1;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim decode and next-state after touching a way.
// Node n has children 2n+1 (lower ways) and 2n+2 (upper ways); a 0 bit sends the victim left.
module plru_tree
    import cache_pkg::*;
#(
    parameter  int WAYS   = 2,
    localparam int WAY_W  = way_width_f(WAYS),
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] plru_i,
    input  logic [WAY_W-1:0]  touch_way_i,
    output logic [WAY_W-1:0]  victim_way_o,
    output logic [PLRU_W-1:0] plru_o
);

    localparam int LEVELS = log2_f(WAYS);

    generate
        if (WAYS == 1) begin : g_direct
            logic inputs_unused;
            assign inputs_unused = ^{plru_i, touch_way_i};
            assign victim_way_o  = '0;
            assign plru_o        = '0;
        end else begin : g_tree
            always_comb begin
                int node;
                int vway;
                node = 0;
                vway = 0;
                for (int l = 0; l < LEVELS; l++) begin
                    for (int n = 0; n < WAYS - 1; n++) begin
                        if (n == node) vway = vway * 2 + (plru_i[n] ? 1 : 0);
                    end
                    node = 2 * node + 1 + (vway % 2);
                end
                victim_way_o = WAY_W'(vway);
            end

            // Every node on the path to the touched way is pointed at the other subtree.
            always_comb begin
                int node;
                int b;
                plru_o = plru_i;
                node   = 0;
                b      = 0;
                for (int l = 0; l < LEVELS; l++) begin
                    b = touch_way_i[LEVELS-1-l] ? 1 : 0;
                    for (int n = 0; n < WAYS - 1; n++) begin
                        if (n == node) plru_o[n] = (b == 0);
                    end
                    node = 2 * node + 1 + b;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cache_memory_assoc.sv
// N-way set-associative tag/data store with tree-PLRU replacement, victim reporting
// and a flush walker that writes back dirty lines and invalidates the whole array.
module cache_memory_assoc
    import cache_pkg::*;
#(
    parameter  int ADDR_WIDTH = 28,
    parameter  int DATA_WIDTH = 32,
    parameter  int BLOCK_SIZE = 256,
    parameter  int CACHE_SIZE = 65536,
    parameter  int WAYS       = 2,
    localparam int WAY_W      = way_width_f(WAYS),
    localparam int TAG_WIDTH  = tag_width_f(ADDR_WIDTH, DATA_WIDTH, BLOCK_SIZE, CACHE_SIZE, WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  lookup_en,
    input  logic                  write_en,
    input  logic [WAY_W-1:0]      write_way,
    input  logic [BLOCK_SIZE-1:0] data_write,
    input  logic                  dirty_write,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [BLOCK_SIZE-1:0] data_read,
    output logic                  dirty_read,
    output logic [WAY_W-1:0]      victim_way,
    output logic [TAG_WIDTH-1:0]  victim_tag,
    output logic                  victim_dirty,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [BLOCK_SIZE-1:0] wb_data,
    output flush_state_e          flush_state
);

    localparam int NUM_SETS     = num_sets_f(CACHE_SIZE, BLOCK_SIZE, WAYS);
    localparam int OFFSET_WIDTH = offset_width_f(BLOCK_SIZE, DATA_WIDTH);
    localparam int INDEX_WIDTH  = index_width_f(CACHE_SIZE, BLOCK_SIZE, WAYS);
    localparam int WAY_BITS     = log2_f(WAYS);
    localparam int LINES        = NUM_SETS * WAYS;
    localparam int LINE_W       = log2_f(LINES);
    localparam int PLRU_W       = (WAYS > 1) ? WAYS - 1 : 1;

    // Storage: only valid and PLRU bits carry a reset value.
    logic [BLOCK_SIZE-1:0] data_q  [LINES];
    logic [TAG_WIDTH-1:0]  tag_q   [LINES];
    logic [LINES-1:0]      dirty_q;
    logic [LINES-1:0]      valid_q;
    logic [PLRU_W-1:0]     plru_q  [NUM_SETS];

    flush_state_e          state_q;
    logic [INDEX_WIDTH-1:0] set_q;
    logic [WAY_W-1:0]      way_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  wb_valid_q;
    logic [ADDR_WIDTH-1:0] wb_addr_q;
    logic [BLOCK_SIZE-1:0] wb_data_q;

    logic [TAG_WIDTH-1:0]   addr_tag;
    logic [INDEX_WIDTH-1:0] addr_set;

    function automatic logic [LINE_W-1:0] line_idx(input logic [INDEX_WIDTH-1:0] s,
                                                    input logic [WAY_W-1:0] w);
        return (LINE_W'(s) << WAY_BITS) | LINE_W'(w);
    endfunction

    assign addr_tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign addr_set = addr[OFFSET_WIDTH +: INDEX_WIDTH];

    generate
        if (OFFSET_WIDTH > 0) begin : g_offset
            logic addr_offset_unused;
            assign addr_offset_unused = ^addr[OFFSET_WIDTH-1:0];
        end
    endgenerate

    // Lookup: lowest matching way wins; everything reads as a miss while the walker owns the array.
    logic             hit_c;
    logic [WAY_W-1:0] hit_way_c;
    logic [LINE_W-1:0] hit_line;

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[line_idx(addr_set, WAY_W'(w))] &&
                (tag_q[line_idx(addr_set, WAY_W'(w))] == addr_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
        if (busy_q) begin
            hit_c     = 1'b0;
            hit_way_c = '0;
        end
    end

    assign hit_line   = line_idx(addr_set, hit_way_c);
    assign hit        = hit_c;
    assign hit_way    = hit_way_c;
    assign data_read  = data_q[hit_line];
    assign dirty_read = hit_c & dirty_q[hit_line];

    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] plru_victim;
    logic [PLRU_W-1:0] plru_next;
    logic [LINE_W-1:0] victim_line;

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[line_idx(addr_set, WAY_W'(w))]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way   = inv_found ? inv_way : plru_victim;
    assign victim_line  = line_idx(addr_set, victim_way);
    assign victim_tag   = tag_q[victim_line];
    assign victim_dirty = valid_q[victim_line] & dirty_q[victim_line];

    // A write outranks a lookup hit for the PLRU touch; hit_c is already gated by busy.
    logic              wr_fire;
    logic              touch_fire;
    logic [WAY_W-1:0]  touch_way;
    logic [LINE_W-1:0] wr_line;

    assign wr_fire    = write_en & ~busy_q;
    assign touch_fire = wr_fire | (lookup_en & hit_c);
    assign touch_way  = wr_fire ? write_way : hit_way_c;
    assign wr_line    = line_idx(addr_set, write_way);

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru_i       (plru_q[addr_set]),
        .touch_way_i  (touch_way),
        .victim_way_o (plru_victim),
        .plru_o       (plru_next)
    );

    always_ff @(posedge clk) begin
        if (rst || state_q == FL_DONE) begin
            for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else if (touch_fire) begin
            plru_q[addr_set] <= plru_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            data_q[wr_line]  <= data_write;
            tag_q[wr_line]   <= addr_tag;
            dirty_q[wr_line] <= dirty_write;
        end
    end

    // Walker position and the line it is currently inspecting.
    logic [LINE_W-1:0]      scan_line;
    logic                   scan_dirty;
    logic                   scan_clear;
    logic                   scan_last;
    logic [INDEX_WIDTH-1:0] adv_set;
    logic [WAY_W-1:0]       adv_way;

    assign scan_line  = line_idx(set_q, way_q);
    assign scan_dirty = valid_q[scan_line] & dirty_q[scan_line];
    assign scan_clear = ((state_q == FL_SCAN) && !scan_dirty) ||
                        ((state_q == FL_WB) && wb_ready);

    always_comb begin
        scan_last = (set_q == INDEX_WIDTH'(NUM_SETS - 1)) && (way_q == WAY_W'(WAYS - 1));
        if (way_q == WAY_W'(WAYS - 1)) begin
            adv_way = '0;
            adv_set = set_q + INDEX_WIDTH'(1);
        end else begin
            adv_way = way_q + WAY_W'(1);
            adv_set = set_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (scan_clear) valid_q[scan_line] <= 1'b0;
            if (wr_fire)    valid_q[wr_line]   <= 1'b1;
        end
    end

    // Writeback port: a line transfers on a cycle with wb_valid && wb_ready; once raised,
    // wb_valid and its wb_addr/wb_data hold unchanged until that transfer (or reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FL_IDLE;
            set_q      <= '0;
            way_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                FL_IDLE: begin
                    if (flush_req) begin
                        state_q <= FL_SCAN;
                        set_q   <= '0;
                        way_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FL_SCAN: begin
                    if (scan_dirty) begin
                        state_q    <= FL_WB;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= {tag_q[scan_line], set_q, {OFFSET_WIDTH{1'b0}}};
                        wb_data_q  <= data_q[scan_line];
                    end else if (scan_last) begin
                        state_q <= FL_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        set_q <= adv_set;
                        way_q <= adv_way;
                    end
                end
                FL_WB: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        if (scan_last) begin
                            state_q <= FL_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FL_SCAN;
                            set_q   <= adv_set;
                            way_q   <= adv_way;
                        end
                    end
                end
                FL_DONE: begin
                    state_q <= FL_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= FL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flush_busy  = busy_q;
    assign flush_done  = done_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign flush_state = state_q;

endmodule

// File: tb/tb_cache_memory_assoc.sv
// Directed bench for cache_memory_assoc at default geometry (2 ways, 1024 sets, tag 15 bits).
module tb_cache_memory_assoc;
    import cache_pkg::*;

    logic         clk;
    logic         rst;
    logic [27:0]  addr;
    logic         lookup_en;
    logic         write_en;
    logic [0:0]   write_way;
    logic [255:0] data_write;
    logic         dirty_write;
    logic         hit;
    logic [0:0]   hit_way;
    logic [255:0] data_read;
    logic         dirty_read;
    logic [0:0]   victim_way;
    logic [14:0]  victim_tag;
    logic         victim_dirty;
    logic         flush_req;
    logic         flush_busy;
    logic         flush_done;
    logic         wb_valid;
    logic         wb_ready;
    logic [27:0]  wb_addr;
    logic [255:0] wb_data;
    flush_state_e flush_state;

    cache_memory_assoc dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .lookup_en    (lookup_en),
        .write_en     (write_en),
        .write_way    (write_way),
        .data_write   (data_write),
        .dirty_write  (dirty_write),
        .hit          (hit),
        .hit_way      (hit_way),
        .data_read    (data_read),
        .dirty_read   (dirty_read),
        .victim_way   (victim_way),
        .victim_tag   (victim_tag),
        .victim_dirty (victim_dirty),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush_state  (flush_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent flush_run.
    int           fr_cycles;
    int           fr_hs;
    logic [27:0]  fr_last_addr;
    logic [255:0] fr_last_data;
    logic         fr_hs_before_done;
    logic         fr_got_done;

    localparam logic [255:0] D_A  = {8{32'h1111_0000}};
    localparam logic [255:0] D_B  = {8{32'h2222_0001}};
    localparam logic [255:0] D_A5 = {32{8'hA5}};
    localparam logic [255:0] D_C  = {8{32'hC0DE_0010}};
    localparam logic [255:0] D_E  = {8{32'h1234_5678}};

    function automatic logic [27:0] mk(input int tag, input int set, input int off);
        return {tag[14:0], set[9:0], off[2:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_line(input logic [27:0] a, input logic w, input logic [255:0] d,
                              input logic dirty);
        addr        = a;
        write_way   = w;
        data_write  = d;
        dirty_write = dirty;
        write_en    = 1'b1;
        step();
        write_en    = 1'b0;
    endtask

    // Runs from the cycle after the flush started until flush_done, bounded.
    task automatic flush_run();
        logic prev_hs;
        fr_cycles = 0; fr_hs = 0; fr_got_done = 1'b0; fr_hs_before_done = 1'b0;
        fr_last_addr = '0; fr_last_data = '0; prev_hs = 1'b0;
        for (int i = 0; i < 5000 && !fr_got_done; i++) begin
            if (flush_busy) fr_cycles++;
            if (flush_done) begin
                fr_got_done       = 1'b1;
                fr_hs_before_done = prev_hs;
            end else begin
                prev_hs = wb_valid && wb_ready;
                if (prev_hs) begin
                    fr_hs++;
                    fr_last_addr = wb_addr;
                    fr_last_data = wb_data;
                end
                step();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst = 1'b1; addr = '0; lookup_en = 1'b0; write_en = 1'b0; write_way = '0;
        data_write = '0; dirty_write = 1'b0; flush_req = 1'b0; wb_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_busy", flush_busy, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_state", flush_state, FL_IDLE);

        // Empty array lookup
        addr = 28'h0000100; lookup_en = 1'b1;
        #1;
        chk("empty_hit", hit, 0);
        chk("empty_victim_way", victim_way, 0);
        chk("empty_victim_dirty", victim_dirty, 0);
        chk("empty_dirty_read", dirty_read, 0);
        step();
        lookup_en = 1'b0;

        // Clean flush: 2048 scan cycles plus the done cycle, no writebacks
        flush_req = 1'b1; step(); flush_req = 1'b0;
        flush_run();
        chk("clean_got_done", fr_got_done, 1);
        chk("clean_cycles", fr_cycles, 2049);
        chk("clean_wb_count", fr_hs, 0);
        seen = wb_valid;
        chk("clean_wb_valid_at_done", seen, 0);
        step();
        chk("clean_busy_after", flush_busy, 0);
        chk("clean_done_pulse", flush_done, 0);

        // Two ways of set 5, PLRU behaviour
        write_line(mk(1, 5, 0), 1'b0, D_A, 1'b0);
        write_line(mk(2, 5, 0), 1'b1, D_B, 1'b0);
        addr = mk(1, 5, 2);
        #1;
        chk("set5_victim_after_writes", victim_way, 0);
        lookup_en = 1'b1;
        #1;
        chk("set5_hit_t1", hit, 1);
        chk("set5_hit_way_t1", hit_way, 0);
        chk("set5_data_t1", data_read, D_A);
        step();
        lookup_en = 1'b0;
        #1;
        chk("set5_victim_after_t1", victim_way, 1);
        chk("set5_victim_tag_after_t1", victim_tag, 15'h0002);
        chk("set5_victim_dirty_clean", victim_dirty, 0);
        addr = mk(2, 5, 7); lookup_en = 1'b1;
        #1;
        chk("set5_hit_t2", hit, 1);
        chk("set5_hit_way_t2", hit_way, 1);
        chk("set5_data_t2", data_read, D_B);
        step();
        lookup_en = 1'b0;
        #1;
        chk("set5_victim_after_t2", victim_way, 0);
        addr = mk(3, 5, 0);
        #1;
        chk("set5_miss_t3", hit, 0);

        // Dirty line with writeback stall
        write_line(mk(7, 3, 0), 1'b1, D_A5, 1'b1);
        addr = mk(7, 3, 1);
        #1;
        chk("set3_hit", hit, 1);
        chk("set3_hit_way", hit_way, 1);
        chk("set3_dirty_read", dirty_read, 1);
        wb_ready = 1'b0;
        flush_req = 1'b1; step(); flush_req = 1'b0;
        #1;
        chk("busy_forces_miss", hit, 0);
        for (int i = 0; i < 3000 && !wb_valid; i++) step();
        chk("stall_wb_reached", wb_valid, 1);
        for (int k = 0; k < 4; k++) begin
            chk("stall_wb_valid", wb_valid, 1);
            chk("stall_wb_addr", wb_addr, mk(7, 3, 0));
            chk("stall_wb_data", wb_data, D_A5);
            step();
        end
        wb_ready = 1'b1;
        #1;
        chk("stall_wb_valid_hs", wb_valid, 1);
        chk("stall_wb_addr_hs", wb_addr, mk(7, 3, 0));
        step();
        chk("stall_wb_dropped", wb_valid, 0);
        flush_run();
        chk("stall_got_done", fr_got_done, 1);
        step();
        addr = mk(7, 3, 0);
        #1;
        chk("set3_miss_after_flush", hit, 0);
        addr = mk(1, 5, 0);
        #1;
        chk("set5_miss_after_flush", hit, 0);

        // Flush request together with a write; the written line is the last writeback
        wb_ready = 1'b1;
        write_line(mk(8'h11, 10, 0), 1'b0, D_C, 1'b1);
        addr = mk(8'h22, 1023, 0); write_way = 1'b1; data_write = D_E; dirty_write = 1'b1;
        write_en = 1'b1; flush_req = 1'b1;
        step();
        write_en = 1'b0; flush_req = 1'b0;
        flush_run();
        chk("same_got_done", fr_got_done, 1);
        chk("same_wb_count", fr_hs, 2);
        chk("same_last_wb_addr", fr_last_addr, mk(8'h22, 1023, 0));
        chk("same_last_wb_data", fr_last_data, D_E);
        chk("same_wb_then_done", fr_hs_before_done, 1);
        chk("same_cycles", fr_cycles, 2051);
        step();
        addr = mk(8'h22, 1023, 0);
        #1;
        chk("same_miss_after", hit, 0);

        // Reset while a writeback is pending
        wb_ready = 1'b0;
        write_line(mk(5, 0, 0), 1'b0, D_A, 1'b1);
        flush_req = 1'b1; step(); flush_req = 1'b0;
        for (int i = 0; i < 20 && !wb_valid; i++) step();
        chk("rstwb_reached", wb_valid, 1);
        chk("rstwb_state", flush_state, FL_WB);
        rst = 1'b1;
        step();
        chk("rstwb_wb_valid", wb_valid, 0);
        chk("rstwb_busy", flush_busy, 0);
        chk("rstwb_done", flush_done, 0);
        chk("rstwb_state_idle", flush_state, FL_IDLE);
        rst = 1'b0;
        addr = mk(5, 0, 0);
        #1;
        chk("rstwb_miss", hit, 0);
        chk("rstwb_victim_dirty", victim_dirty, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (flush_done || wb_valid) seen = 1'b1;
        end
        chk("rstwb_quiet", seen, 0);

        // Writes ignored while the walker is active
        wb_ready = 1'b1;
        write_line(mk(8'h44, 1000, 0), 1'b0, D_B, 1'b0);
        flush_req = 1'b1; step(); flush_req = 1'b0;
        repeat (20) step();
        addr = mk(8'h44, 1000, 0); lookup_en = 1'b1;
        #1;
        chk("busy_hit_forced", hit, 0);
        chk("busy_hit_way_forced", hit_way, 0);
        lookup_en = 1'b0;
        write_line(mk(8'h33, 0, 0), 1'b0, D_C, 1'b1);
        flush_run();
        chk("busywr_got_done", fr_got_done, 1);
        chk("busywr_no_wb", fr_hs, 0);
        step();
        addr = mk(8'h33, 0, 0);
        #1;
        chk("busywr_miss", hit, 0);
        addr = mk(8'h44, 1000, 0);
        #1;
        chk("busywr_set1000_miss", hit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_memory_assoc.md
Name: cache_memory_assoc

Overview:
Parametrised N-way set-associative tag/data store. It is the successor of the direct-mapped cache memory and sits under the cache controller FSM. Adds per-set tree-PLRU replacement and victim reporting. Adds a hardware flush walker that writes back dirty lines over a valid/ready port and invalidates every line, replacing the controller's per-index flush loop.

Parameters:
ADDR_WIDTH, 28, word address width
DATA_WIDTH, 32, word width
BLOCK_SIZE, 256, line width in bits
CACHE_SIZE, 65536, capacity in bytes
WAYS, 2, associativity; power of 2, 1..8 (1 = direct-mapped, PLRU absent)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
addr  in  ADDR_WIDTH  lookup/write word address {tag, set, offset}
lookup_en  in  1  qualifies addr as a real access; updates PLRU on hit
write_en  in  1  write line at (set(addr), write_way)
write_way  in  log2(WAYS)  target way for write
data_write  in  BLOCK_SIZE  line data to write
dirty_write  in  1  dirty bit to write
hit  out  1  a valid way matches tag(addr)
hit_way  out  log2(WAYS)  matching way (0 when no hit)
data_read  out  BLOCK_SIZE  line in hit_way
dirty_read  out  1  dirty bit of hit_way
victim_way  out  log2(WAYS)  replacement way for set(addr)
victim_tag  out  TAG_WIDTH  tag stored in victim_way
victim_dirty  out  1  valid & dirty of victim_way
flush_req  in  1  pulse: start flush
flush_busy  out  1  walker active
flush_done  out  1  one-cycle pulse at flush completion
wb_valid  out  1  dirty line presented for writeback
wb_ready  in  1  downstream accepts writeback
wb_addr  out  ADDR_WIDTH  {tag, set, offset=0} of the written-back line
wb_data  out  BLOCK_SIZE  written-back line data

Behaviour:
- Derived widths: NUM_SETS = CACHE_SIZE*8/BLOCK_SIZE/WAYS; OFFSET_WIDTH = log2(BLOCK_SIZE/DATA_WIDTH); INDEX_WIDTH = log2(NUM_SETS); TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH. Defaults give 1024 sets, offset 3, index 10, tag 15.
- Storage: the data/tag/dirty arrays hold no reset value. Valid bits are a flop vector of NUM_SETS*WAYS, all cleared in the reset cycle. PLRU bits (WAYS-1 per set) are cleared on reset.
- Lookup is combinational, zero latency, and is forced miss while flush_busy: hit=0, hit_way=0.
- Multiple tag matches cannot occur; if they do, the lowest way wins.
- Victim selection: lowest-index invalid way in the set. If all ways are valid, the tree-PLRU way. victim_* are combinational.
- Write (write_en=1, not busy): on the next posedge the line stores data_write, tag(addr), dirty_write, valid=1. PLRU is updated to point away from write_way.
- lookup_en=1 with hit=1 and no write in the same cycle updates PLRU away from hit_way. A write takes PLRU priority when both occur.
- Reset values: hit=0, dirty_read=0, victim_dirty=0, victim_way=0, flush_busy=0, flush_done=0, wb_valid=0. wb_addr and wb_data are don't-care while wb_valid=0.
- Flush FSM:
  - IDLE: flush_req -> SCAN with set=0, way=0, flush_busy=1 from the next cycle.
  - SCAN: if the current line is valid & dirty -> WB. Otherwise clear its valid bit and advance.
  - WB: hold wb_valid=1 with stable wb_addr/wb_data until wb_ready=1. In the handshake cycle, clear valid and advance.
  - Advance order: way first, then set. After (NUM_SETS-1, WAYS-1) -> DONE.
  - DONE: flush_done=1 for one cycle, clear PLRU of all sets, -> IDLE with flush_busy=0.
- Flush duration: clean cache = NUM_SETS*WAYS SCAN cycles + 1 DONE cycle. Each dirty line adds 1 cycle plus its wb_ready stall.
- Simultaneous events:
  - flush_req with write_en in IDLE: the write commits, then the flush starts and sweeps that line too.
  - write_en and lookup_en while busy: ignored, no state change.
  - flush_req while busy: ignored.
- wb_valid never deasserts without wb_ready, except on reset.
- Reset mid-flush: FSM -> IDLE, all valid cleared, no flush_done, wb_valid drops that cycle.

Decomposition:
- Shared package cache_pkg holds the log2 function and the derived-width computations shared with the cache controller.
- Sub-module plru_tree (combinational next-state and victim decode for one set; WAYS parameter) instantiated once on the addressed set's PLRU bits.
- Flush FSM stays inline.

Test Plan:
- Reset, then lookup at addr 0x0000100 -> hit=0, victim_way=0, victim_dirty=0. Then a clean flush takes exactly 2049 cycles flush_busy-to-done with wb_valid never asserted.
- Write way0 at tag 0x0001 and way1 at tag 0x0002, both set 5. Lookup tag 0x0001 with lookup_en -> hit=1, hit_way=0; then victim_way=1. Lookup tag 0x0002 -> victim_way=0.
- Write way1 at set 3 with dirty_write=1 and data 0xA5..A5, then flush with wb_ready held low 4 cycles -> wb_valid stays high with stable wb_addr={tag,3,3'b0}. Handshake happens on the 5th cycle; later hit=0.
- Same cycle flush_req and write_en, dirty line at set 1023 way1 -> that line is the last writeback before the flush_done pulse.
- Assert rst during WB state -> next cycle wb_valid=0, flush_busy=0, no flush_done, all lookups miss.
- write_en while flush_busy=1 -> no write; after flush completes, a lookup of that address misses.
